// File: rtl/mem_read_pkg.sv
// rtl/mem_read_pkg.sv - state encoding and default widths for the read master
// Purpose: shared types and constants imported by the read master and its FIFO.
// Ports: none (package).
package mem_read_pkg;

  localparam int DEF_DATAWIDTH       = 32;
  localparam int DEF_BYTEENABLEWIDTH = 4;
  localparam int DEF_ADDRESSWIDTH    = 32;
  localparam int DEF_LENGTHWIDTH     = 32;
  localparam int DEF_FIFODEPTH       = 32;
  localparam int DEF_FIFODEPTH_LOG2  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mem_read_master_fifo_if.sv
// rtl/mem_read_master_fifo_if.sv - Avalon-MM read bus between master and memory slave
// Purpose: bundles the read-request and read-return signals of the bus.
// Ports (modport master): out master_address/master_read/master_byteenable,
//   in master_readdata/master_readdatavalid/master_waitrequest; modport slave mirrors them.
interface mem_read_master_fifo_if
  import mem_read_pkg::*;
#(
  parameter int DATAWIDTH       = DEF_DATAWIDTH,
  parameter int BYTEENABLEWIDTH = DEF_BYTEENABLEWIDTH,
  parameter int ADDRESSWIDTH    = DEF_ADDRESSWIDTH
);

  logic [ADDRESSWIDTH-1:0]    master_address;
  logic                       master_read;
  logic [BYTEENABLEWIDTH-1:0] master_byteenable;
  logic [DATAWIDTH-1:0]       master_readdata;
  logic                       master_readdatavalid;
  logic                       master_waitrequest;

  modport master (
    output master_address,
    output master_read,
    output master_byteenable,
    input  master_readdata,
    input  master_readdatavalid,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_read,
    input  master_byteenable,
    output master_readdata,
    output master_readdatavalid,
    output master_waitrequest
  );

endinterface

// File: rtl/mem_read_fifo.sv
// rtl/mem_read_fifo.sv - single-clock show-ahead FIFO for returned read words
// Purpose: buffers words; head_data is valid whenever empty=0.
// Ports: clk, reset_n (async, active-low); push/push_data write; pop removes head
//   (ignored when empty); head_data, used (0..depth), empty.
module mem_read_fifo
  import mem_read_pkg::*;
#(
  parameter int DATAWIDTH      = DEF_DATAWIDTH,
  parameter int FIFODEPTH_LOG2 = DEF_FIFODEPTH_LOG2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [DATAWIDTH-1:0]      push_data,
  input  logic                      pop,
  output logic [DATAWIDTH-1:0]      head_data,
  output logic [FIFODEPTH_LOG2:0]   used,
  output logic                      empty
);

  localparam int DEPTH = 1 << FIFODEPTH_LOG2;

  logic [DATAWIDTH-1:0]      mem_q [DEPTH];
  logic [FIFODEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFODEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFODEPTH_LOG2:0]   used_q, used_d;
  logic                      pop_eff;

  // Producer never pushes into a full FIFO (credit-throttled upstream).
  always_comb begin
    pop_eff  = pop && (used_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_eff) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop_eff) used_d = used_q + 1'b1;
    else if (!push && pop_eff) used_d = used_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign used      = used_q;
  assign empty     = (used_q == '0);

endmodule

// File: rtl/mem_read_master_fifo.sv
// rtl/mem_read_master_fifo.sv - pipelined Avalon-MM read master with show-ahead read buffer
// Purpose: on ctl_go reads ctl_read_length bytes from ctl_read_base as pipelined
//   word reads, throttled so outstanding + buffered words never exceed FIFODEPTH.
// Ports: clk, reset_n (async, active-low); ctl_go/ctl_read_base/ctl_read_length in,
//   ctl_done/ctl_early_done out; user_read in, user_data/user_data_available out;
//   m: Avalon-MM read master bus.
module mem_read_master_fifo
  import mem_read_pkg::*;
#(
  parameter int DATAWIDTH       = DEF_DATAWIDTH,
  parameter int BYTEENABLEWIDTH = DEF_BYTEENABLEWIDTH,
  parameter int ADDRESSWIDTH    = DEF_ADDRESSWIDTH,
  parameter int LENGTHWIDTH     = DEF_LENGTHWIDTH,
  parameter int FIFODEPTH       = DEF_FIFODEPTH,
  parameter int FIFODEPTH_LOG2  = DEF_FIFODEPTH_LOG2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ctl_go,
  input  logic [ADDRESSWIDTH-1:0]  ctl_read_base,
  input  logic [LENGTHWIDTH-1:0]   ctl_read_length,
  output logic                     ctl_done,
  output logic                     ctl_early_done,
  input  logic                     user_read,
  output logic [DATAWIDTH-1:0]     user_data,
  output logic                     user_data_available,
  mem_read_master_fifo_if.master   m
);

  localparam int CW = FIFODEPTH_LOG2 + 1;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [LENGTHWIDTH-1:0]  remaining_q, remaining_d;
  logic [CW-1:0]           pending_q, pending_d;

  logic [CW-1:0] fifo_used;
  logic          fifo_empty;
  logic [CW:0]   credit_sum;
  logic          read_req;
  logic          accept;
  logic          push;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;

    // Words in flight plus words buffered may not exceed the FIFO size.
    credit_sum = {1'b0, pending_q} + {1'b0, fifo_used};
    read_req   = (state_q == ST_READ) && (remaining_q != '0) &&
                 (credit_sum < (CW+1)'(FIFODEPTH));
    accept     = read_req && !m.master_waitrequest;
    // Returns with nothing outstanding are leftovers from before a reset.
    push       = m.master_readdatavalid && (pending_q != '0);
    pending_d  = pending_q + CW'(accept) - CW'(push);

    unique case (state_q)
      ST_IDLE: begin
        if (ctl_go && (ctl_read_length != '0)) begin
          state_d     = ST_READ;
          addr_d      = ctl_read_base;
          remaining_d = ctl_read_length;
        end
      end
      ST_READ: begin
        if (accept) begin
          addr_d = addr_q + ADDRESSWIDTH'(BYTEENABLEWIDTH);
          if (remaining_q <= LENGTHWIDTH'(BYTEENABLEWIDTH)) begin
            remaining_d = '0;
            state_d     = ST_DRAIN;
          end else begin
            remaining_d = remaining_q - LENGTHWIDTH'(BYTEENABLEWIDTH);
          end
        end
      end
      ST_DRAIN: begin
        if (pending_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
    end
  end

  mem_read_fifo #(
    .DATAWIDTH      (DATAWIDTH),
    .FIFODEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (m.master_readdata),
    .pop       (user_read),
    .head_data (user_data),
    .used      (fifo_used),
    .empty     (fifo_empty)
  );

  assign m.master_address     = addr_q;
  assign m.master_read        = read_req;
  assign m.master_byteenable  = '1;
  assign ctl_done             = (state_q == ST_IDLE);
  assign ctl_early_done       = (state_q != ST_READ);
  assign user_data_available  = !fifo_empty;

endmodule
